iic_txn_sched: RTL

// Round-robin scheduler that shares one iic_core byte engine between NREQ requesters.

---
 rtl/iic_txn_sched_if.sv | 40 ++++
 rtl/iic_txn_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iic_txn_sched_if.sv
// Requester-side and core-FIFO-side signal bundle for the IIC transaction scheduler.
// The scheduler uses the slave modport; the requesters and the core model use the master modport.
interface iic_txn_sched_if #(
    parameter int NREQ = 4,
    parameter int LENW = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*7-1:0]    req_addr;
    logic [NREQ-1:0]      req_rw;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      gnt;
    logic [NREQ*8-1:0]    wr_data;
    logic [NREQ-1:0]      wr_valid;
    logic [NREQ-1:0]      wr_ready;
    logic [7:0]           rd_data;
    logic [NREQ-1:0]      rd_valid;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic                 tx_fifo_wr;
    logic [7:0]           tx_fifo_din;
    logic                 tx_fifo_full;
    logic                 tx_fifo_empty;
    logic                 rx_fifo_rd;
    logic [7:0]           rx_fifo_dout;
    logic                 rx_fifo_empty;

    modport slave (
        input  req, req_addr, req_rw, req_len, wr_data, wr_valid,
        input  tx_fifo_full, tx_fifo_empty, rx_fifo_dout, rx_fifo_empty,
        output gnt, wr_ready, rd_data, rd_valid, done, err,
        output tx_fifo_wr, tx_fifo_din, rx_fifo_rd
    );

    modport master (
        output req, req_addr, req_rw, req_len, wr_data, wr_valid,
        output tx_fifo_full, tx_fifo_empty, rx_fifo_dout, rx_fifo_empty,
        input  gnt, wr_ready, rd_data, rd_valid, done, err,
        input  tx_fifo_wr, tx_fifo_din, rx_fifo_rd
    );
endinterface

// File: rtl/iic_txn_sched.sv
// Round-robin scheduler sharing one iic_core byte engine between NREQ requesters;
// serialises address byte + payload into the core tx FIFO and returns rx bytes to the winner.
module iic_txn_sched #(
    parameter int NREQ    = 4,
    parameter int LENW    = 4,
    parameter int TIMEOUT = 200000,
    parameter int GAP_CYC = 200
) (
    input  logic            clk,
    input  logic            reset_n,
    iic_txn_sched_if.slave  bus
);
    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WDRAIN, S_RDATA, S_DONE, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d, idx_q, idx_d;
    logic [6:0]        addr_q, addr_d;
    logic              rw_q, rw_d, err_q, err_d;
    logic [LENW-1:0]   len_q, len_d, bcnt_q, bcnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [NREQ-1:0]   rd_valid_q, rd_valid_d;

    logic [6:0]        addr_a  [NREQ];
    logic [LENW-1:0]   len_a   [NREQ];
    logic [7:0]        wdata_a [NREQ];
    logic [NREQ-1:0]   sel_oh;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_a[gi]  = bus.req_addr[7*gi +: 7];
            assign len_a[gi]   = bus.req_len[LENW*gi +: LENW];
            assign wdata_a[gi] = bus.wr_data[8*gi +: 8];
            assign sel_oh[gi]  = (idx_q == IW'(gi));
        end
    endgenerate

    // First pending request at or above the rr pointer, wrapping at NREQ.
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [IW:0]   cand;
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (IW+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!pick_vld && bus.req[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    logic [IW:0]   rr_inc;
    logic [IW-1:0] rr_next;
    assign rr_inc  = {1'b0, pick_idx} + (IW+1)'(1);
    assign rr_next = (rr_inc == NREQ_W) ? '0 : rr_inc[IW-1:0];

    logic            tx_wr, rx_rd, last_byte, timer_hit;
    logic [7:0]      tx_din;
    logic [NREQ-1:0] wr_rdy;
    assign last_byte = (bcnt_q == len_q - LENW'(1));
    assign timer_hit = (cnt_q == T_LAST);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        len_d      = len_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        tx_wr      = 1'b0;
        tx_din     = '0;
        rx_rd      = 1'b0;
        wr_rdy     = '0;
        unique case (state_q)
            S_IDLE: if (pick_vld) begin
                idx_d   = pick_idx;
                addr_d  = addr_a[pick_idx];
                rw_d    = bus.req_rw[pick_idx];
                len_d   = len_a[pick_idx];
                rr_d    = rr_next;
                err_d   = 1'b0;
                state_d = S_ADDR;
            end
            S_ADDR: if (!bus.tx_fifo_full) begin
                tx_wr  = 1'b1;
                tx_din = {addr_q, rw_q};
                bcnt_d = '0;
                cnt_d  = '0;
                if (len_q == '0) state_d = S_WDRAIN;
                else if (rw_q)   state_d = S_RDATA;
                else             state_d = S_WDATA;
            end
            S_WDATA: begin
                wr_rdy = sel_oh & {NREQ{!bus.tx_fifo_full}};
                if (!bus.tx_fifo_full && bus.wr_valid[idx_q]) begin
                    tx_wr  = 1'b1;
                    tx_din = wdata_a[idx_q];
                    bcnt_d = bcnt_q + LENW'(1);
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = S_WDRAIN;
                    end
                end
            end
            S_WDRAIN: begin
                if (bus.tx_fifo_empty) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timer_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RDATA: begin
                // A pop is progress, so it wins over a coincident timer expiry.
                if (!bus.rx_fifo_empty) begin
                    rx_rd      = 1'b1;
                    rd_data_d  = bus.rx_fifo_dout;
                    rd_valid_d = sel_oh;
                    bcnt_d     = bcnt_q + LENW'(1);
                    cnt_d      = '0;
                    if (last_byte) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end else if (timer_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == G_LAST) state_d = S_IDLE;
                else                 cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            len_q      <= '0;
            bcnt_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            bcnt_q     <= bcnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    logic in_txn, in_done;
    assign in_txn  = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_WDRAIN)
                  || (state_q == S_RDATA) || (state_q == S_DONE);
    assign in_done = (state_q == S_DONE);

    assign bus.gnt         = in_txn  ? sel_oh : '0;
    assign bus.done        = in_done ? sel_oh : '0;
    assign bus.err         = in_done & err_q;
    assign bus.wr_ready    = wr_rdy;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.tx_fifo_wr  = tx_wr;
    assign bus.tx_fifo_din = tx_din;
    assign bus.rx_fifo_rd  = rx_rd;
endmodule
